// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: position map, word typedefs and the syndrome
// calculation used by both the decoder and the matching encoder.
package hamming_pkg;

  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned D1 = 3;
  localparam int unsigned P4 = 4;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;
  localparam int unsigned D4 = 7;

  typedef logic [7:1] code7_t;
  typedef logic [4:1] data4_t;
  typedef logic [3:1] syndrome_t;

  // Each group XOR equals parity_type on a clean word, so the syndrome bit is
  // the group XOR with the selected parity folded out.
  function automatic syndrome_t calc_syndrome(input code7_t c, input logic parity_type);
    logic x1;
    logic x2;
    logic x4;
    x1 = c[P1] ^ c[D1] ^ c[D2] ^ c[D4];
    x2 = c[P2] ^ c[D1] ^ c[D3] ^ c[D4];
    x4 = c[P4] ^ c[D2] ^ c[D3] ^ c[D4];
    return {x4 ^ parity_type, x2 ^ parity_type, x1 ^ parity_type};
  endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// Word-in / result-out bundle of the Hamming(7,4) decoder on the RAM read path.
interface hamming_decoder_if;
  import hamming_pkg::*;

  logic        in_valid;
  code7_t      code_in;
  logic        parity_type;
  logic        out_valid;
  data4_t      data_out;
  logic        error;
  syndrome_t   syndrome;
  logic [15:0] err_count;

  modport master (
    output in_valid, code_in, parity_type,
    input  out_valid, data_out, error, syndrome, err_count
  );

  modport slave (
    input  in_valid, code_in, parity_type,
    output out_valid, data_out, error, syndrome, err_count
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator: {s4,s2,s1} gives the erroneous bit position.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  code7_t    code_in,
  input  logic      parity_type,
  output syndrome_t syndrome
);

  always_comb begin
    syndrome = calc_syndrome(code_in, parity_type);
  end

endmodule

// File: rtl/hamming_decoder.sv
// Registered Hamming(7,4) SEC decoder: corrects the bit named by the syndrome,
// extracts data one cycle later and keeps a saturating error counter.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  hamming_decoder_if.slave   bus
);

  syndrome_t   syn;
  code7_t      corrected;
  data4_t      data_ext;

  logic        out_valid_d, out_valid_q;
  data4_t      data_d,      data_q;
  logic        error_d,     error_q;
  syndrome_t   syndrome_d,  syndrome_q;
  logic [15:0] err_count_d, err_count_q;

  hamming_syndrome u_syndrome (
    .code_in     (bus.code_in),
    .parity_type (bus.parity_type),
    .syndrome    (syn)
  );

  // A zero syndrome matches no position, so clean words pass through untouched.
  always_comb begin
    corrected = bus.code_in;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (syn == syndrome_t'(i)) begin
        corrected[i] = ~bus.code_in[i];
      end
    end
    data_ext = {corrected[D4], corrected[D3], corrected[D2], corrected[D1]};
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    data_d      = data_q;
    error_d     = error_q;
    syndrome_d  = syndrome_q;
    err_count_d = err_count_q;
    if (bus.in_valid) begin
      data_d     = data_ext;
      error_d    = (syn != '0);
      syndrome_d = syn;
      if ((syn != '0) && (err_count_q != '1)) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      error_q     <= 1'b0;
      syndrome_q  <= '0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      error_q     <= error_d;
      syndrome_q  <= syndrome_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.error     = error_q;
  assign bus.syndrome  = syndrome_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: hand-worked vectors, exhaustive single-bit
// flips against a local encoder, streaming/gap behaviour, async reset, saturation.
module tb_hamming_decoder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_cnt;

  hamming_decoder_if bus ();

  hamming_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:1] encode(input logic [4:1] d, input logic pt);
    logic [7:1] c;
    c[3] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[7] = d[4];
    c[1] = d[1] ^ d[2] ^ d[4] ^ pt;
    c[2] = d[1] ^ d[3] ^ d[4] ^ pt;
    c[4] = d[2] ^ d[3] ^ d[4] ^ pt;
    return c;
  endfunction

  task automatic send(input logic [7:1] cw, input logic pt);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.code_in     = cw;
    bus.parity_type = pt;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [4:1] d, input logic [3:1] syn);
    if (syn != 3'd0 && exp_cnt < 65535) exp_cnt++;
    check_eq({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, " data_out"},  32'(bus.data_out),  32'(d));
    check_eq({tag, " syndrome"},  32'(bus.syndrome),  32'(syn));
    check_eq({tag, " error"},     32'(bus.error),     32'(syn != 3'd0));
    check_eq({tag, " err_count"}, 32'(bus.err_count), 32'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:1] cw;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.code_in     = '0;
    bus.parity_type = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset data_out",  32'(bus.data_out),  32'd0);
    check_eq("reset syndrome",  32'(bus.syndrome),  32'd0);
    check_eq("reset error",     32'(bus.error),     32'd0);
    check_eq("reset err_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Even parity, bit5 in error; result must not appear before the edge.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.code_in     = 7'b1011011;
    bus.parity_type = 1'b0;
    #1;
    check_eq("v1 pre-edge out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    expect_word("v1 even bit5", 4'b1000, 3'b101);

    send(7'b1010110, 1'b1);
    expect_word("v2 odd bit4", 4'b1011, 3'b100);

    send(7'b1010101, 1'b0);
    expect_word("v3 even clean", 4'b1011, 3'b000);

    for (int d = 0; d < 16; d++) begin
      for (int pt = 0; pt < 2; pt++) begin
        for (int pos = 0; pos < 8; pos++) begin
          cw = encode(d[3:0], pt[0]);
          if (pos != 0) cw[pos] = ~cw[pos];
          send(cw, pt[0]);
          expect_word($sformatf("sweep d=%0d pt=%0d pos=%0d", d, pt, pos), d[3:0], pos[2:0]);
        end
      end
    end

    // Back-to-back words with alternating parity, then a one-cycle gap.
    send(encode(4'b0110, 1'b0), 1'b0);
    expect_word("b2b0", 4'b0110, 3'b000);
    cw = encode(4'b1001, 1'b1);
    cw[6] = ~cw[6];
    send(cw, 1'b1);
    expect_word("b2b1", 4'b1001, 3'b110);
    cw = encode(4'b0011, 1'b0);
    cw[1] = ~cw[1];
    send(cw, 1'b0);
    expect_word("b2b2", 4'b0011, 3'b001);
    cw = encode(4'b1110, 1'b1);
    cw[7] = ~cw[7];
    send(cw, 1'b1);
    expect_word("b2b3", 4'b1110, 3'b111);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.code_in  = 7'b0000001;
    @(posedge clk);
    #1;
    check_eq("gap out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("gap data hold", 32'(bus.data_out),  32'(4'b1110));
    check_eq("gap syn hold",  32'(bus.syndrome),  32'(3'b111));
    check_eq("gap err hold",  32'(bus.error),     32'd1);
    check_eq("gap err_count", 32'(bus.err_count), 32'(exp_cnt));

    // Async reset mid-cycle with a word being presented: it must be dropped.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.code_in     = 7'b0000001;
    bus.parity_type = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async rst out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("async rst data_out",  32'(bus.data_out),  32'd0);
    check_eq("async rst syndrome",  32'(bus.syndrome),  32'd0);
    check_eq("async rst error",     32'(bus.error),     32'd0);
    check_eq("async rst err_count", 32'(bus.err_count), 32'd0);
    @(posedge clk);
    #1;
    check_eq("held rst out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("held rst err_count", 32'(bus.err_count), 32'd0);

    // Continuous erroneous words from the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check_eq("sat 65534", 32'(bus.err_count), 32'hFFFE);
    @(posedge clk);
    #1;
    check_eq("sat 65535", 32'(bus.err_count), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check_eq("sat 65540", 32'(bus.err_count), 32'hFFFF);
    check_eq("sat syndrome", 32'(bus.syndrome), 32'd1);
    check_eq("sat data_out", 32'(bus.data_out), 32'd0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
